// File: rtl/uv_sram_sp_arb_pkg.sv
// Shared definitions for the single-port SRAM arbiter: response-slot states
// and port index constants.
package uv_sram_sp_arb_pkg;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_PEND  = 2'd1,
      SLOT_FULL  = 2'd2
   } slot_t;

   localparam int PORT0 = 0;
   localparam int PORT1 = 1;
   localparam int NPORT = 2;

endpackage

// File: rtl/uv_rr_arb2.sv
// Two-input round-robin arbiter with a one-hot grant; the priority pointer
// moves away from the granted port only when a grant is taken.
module uv_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_gnt
);

   logic r_prio;

   // Contention resolves toward r_prio; a lone request wins outright.
   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = r_prio ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (i_advance) begin
         r_prio <= o_gnt[0];
      end
   end

endmodule

// File: rtl/uv_sram_sp_arb.sv
// Two-port round-robin sequencer in front of one single-port SRAM with a
// one-cycle read latency; each port owns a response slot so stalls lose nothing.
module uv_sram_sp_arb
   import uv_sram_sp_arb_pkg::*;
#(
   parameter int RAM_AW = 8,
   parameter int RAM_DW = 32,
   parameter int RAM_MW = RAM_DW / 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              p0_req_vld,
   output logic              p0_req_rdy,
   input  logic              p0_req_we,
   input  logic [RAM_AW-1:0] p0_req_addr,
   input  logic [RAM_DW-1:0] p0_req_data,
   input  logic [RAM_MW-1:0] p0_req_mask,
   output logic              p0_rsp_vld,
   input  logic              p0_rsp_rdy,
   output logic [RAM_DW-1:0] p0_rsp_data,

   input  logic              p1_req_vld,
   output logic              p1_req_rdy,
   input  logic              p1_req_we,
   input  logic [RAM_AW-1:0] p1_req_addr,
   input  logic [RAM_DW-1:0] p1_req_data,
   input  logic [RAM_MW-1:0] p1_req_mask,
   output logic              p1_rsp_vld,
   input  logic              p1_rsp_rdy,
   output logic [RAM_DW-1:0] p1_rsp_data,

   output logic              ram_ce,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_a,
   output logic [RAM_DW-1:0] ram_d,
   output logic [RAM_MW-1:0] ram_m,
   input  logic [RAM_DW-1:0] ram_q
);

   logic [NPORT-1:0]  w_reqVld;
   logic [NPORT-1:0]  w_reqWe;
   logic [NPORT-1:0]  w_rspRdy;
   logic [NPORT-1:0]  w_rspVld;
   logic [NPORT-1:0]  w_elig;
   logic [NPORT-1:0]  w_arbReq;
   logic [NPORT-1:0]  w_gnt;
   logic [RAM_DW-1:0] w_rspData [NPORT];

   assign w_reqVld = {p1_req_vld, p0_req_vld};
   assign w_reqWe  = {p1_req_we,  p0_req_we};
   assign w_rspRdy = {p1_rsp_rdy, p0_rsp_rdy};

   // Holding reset low must keep the SRAM idle even if requesters keep vld high.
   assign w_arbReq = w_elig & {NPORT{rst_n}};

   uv_rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (w_arbReq),
      .i_advance (|w_gnt),
      .o_gnt     (w_gnt)
   );

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_slot
      slot_t             r_state;
      slot_t             w_stateNxt;
      logic              r_isRd;
      logic              w_isRdNxt;
      logic [RAM_DW-1:0] r_buf;
      logic [RAM_DW-1:0] w_bufNxt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_isRd  <= 1'b0;
            r_buf   <= '0;
         end else begin
            r_state <= w_stateNxt;
            r_isRd  <= w_isRdNxt;
            r_buf   <= w_bufNxt;
         end
      end

      // A fresh grant overrides the drain path; the grant itself already
      // implies the previous response is being consumed this cycle.
      always_comb begin
         w_stateNxt = r_state;
         w_isRdNxt  = r_isRd;
         w_bufNxt   = r_buf;
         case (r_state)
            SLOT_PEND: begin
               if (w_rspRdy[gi]) begin
                  w_stateNxt = SLOT_EMPTY;
               end else begin
                  w_stateNxt = SLOT_FULL;
                  w_bufNxt   = r_isRd ? ram_q : '0;
               end
            end
            SLOT_FULL: begin
               if (w_rspRdy[gi]) begin
                  w_stateNxt = SLOT_EMPTY;
               end
            end
            default: w_stateNxt = SLOT_EMPTY;
         endcase
         if (w_gnt[gi]) begin
            w_stateNxt = SLOT_PEND;
            w_isRdNxt  = !w_reqWe[gi];
         end
      end

      assign w_elig[gi]    = w_reqVld[gi] & ((r_state == SLOT_EMPTY) | w_rspRdy[gi]);
      assign w_rspVld[gi]  = (r_state == SLOT_PEND) | (r_state == SLOT_FULL);
      assign w_rspData[gi] = (r_state == SLOT_FULL) ? r_buf :
                             ((r_state == SLOT_PEND) && r_isRd) ? ram_q : '0;
   end

   assign p0_req_rdy  = w_gnt[PORT0];
   assign p1_req_rdy  = w_gnt[PORT1];
   assign p0_rsp_vld  = w_rspVld[PORT0];
   assign p1_rsp_vld  = w_rspVld[PORT1];
   assign p0_rsp_data = w_rspData[PORT0];
   assign p1_rsp_data = w_rspData[PORT1];

   always_comb begin
      ram_ce = |w_gnt;
      ram_we = 1'b0;
      ram_a  = p0_req_addr;
      ram_d  = p0_req_data;
      ram_m  = p0_req_mask;
      if (w_gnt[PORT1]) begin
         ram_we = p1_req_we;
         ram_a  = p1_req_addr;
         ram_d  = p1_req_data;
         ram_m  = p1_req_mask;
      end else if (w_gnt[PORT0]) begin
         ram_we = p0_req_we;
      end
   end

endmodule

// File: tb/tb_uv_sram_sp_arb.sv
// Directed bench for uv_sram_sp_arb with a behavioural single-port SRAM and
// per-port scoreboard queues drained by a response monitor.
module tb_uv_sram_sp_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        p0_req_vld = 1'b0, p1_req_vld = 1'b0;
   logic        p0_req_rdy, p1_req_rdy;
   logic        p0_req_we = 1'b0, p1_req_we = 1'b0;
   logic [7:0]  p0_req_addr = '0, p1_req_addr = '0;
   logic [31:0] p0_req_data = '0, p1_req_data = '0;
   logic [3:0]  p0_req_mask = '0, p1_req_mask = '0;
   logic        p0_rsp_vld, p1_rsp_vld;
   logic        p0_rsp_rdy = 1'b1, p1_rsp_rdy = 1'b1;
   logic [31:0] p0_rsp_data, p1_rsp_data;

   logic        ram_ce, ram_we;
   logic [7:0]  ram_a;
   logic [31:0] ram_d;
   logic [3:0]  ram_m;
   logic [31:0] ram_q;

   logic [31:0] mem [256];
   logic [31:0] expQ0 [$];
   logic [31:0] expQ1 [$];
   int          gntLog [$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   uv_sram_sp_arb #(.RAM_AW(8), .RAM_DW(32), .RAM_MW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_vld(p0_req_vld), .p0_req_rdy(p0_req_rdy), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data), .p0_req_mask(p0_req_mask),
      .p0_rsp_vld(p0_rsp_vld), .p0_rsp_rdy(p0_rsp_rdy), .p0_rsp_data(p0_rsp_data),
      .p1_req_vld(p1_req_vld), .p1_req_rdy(p1_req_rdy), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data), .p1_req_mask(p1_req_mask),
      .p1_rsp_vld(p1_rsp_vld), .p1_rsp_rdy(p1_rsp_rdy), .p1_rsp_data(p1_rsp_data),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d),
      .ram_m(ram_m), .ram_q(ram_q)
   );

   // Behavioural SRAM: byte-masked writes, registered read data one cycle later.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      ram_q = '0;
   end

   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) begin
            logic [31:0] word;
            word = mem[ram_a];
            for (int b = 0; b < 4; b++) begin
               if (ram_m[b]) word[8*b +: 8] = ram_d[8*b +: 8];
            end
            mem[ram_a] <= word;
         end else begin
            ram_q <= mem[ram_a];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one request, waits (bounded) for acceptance, then queues its expected response.
   task automatic applyStimulus(input int port, input logic we, input logic [7:0] addr,
                                input logic [31:0] data, input logic [3:0] mask,
                                input logic [31:0] expData);
      bit accepted = 0;
      if (port == 0) begin
         p0_req_we = we; p0_req_addr = addr; p0_req_data = data; p0_req_mask = mask;
         p0_req_vld = 1'b1;
      end else begin
         p1_req_we = we; p1_req_addr = addr; p1_req_data = data; p1_req_mask = mask;
         p1_req_vld = 1'b1;
      end
      for (int c = 0; c < 50 && !accepted; c++) begin
         @(negedge clk);
         if ((port == 0) ? p0_req_rdy : p1_req_rdy) begin
            accepted = 1;
            if (port == 0) expQ0.push_back(expData);
            else           expQ1.push_back(expData);
         end
      end
      if (!accepted) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout: port %0d addr %h never granted, expected grant", port, addr);
      end
      @(posedge clk);
      #1;
      if (port == 0) p0_req_vld = 1'b0;
      else           p1_req_vld = 1'b0;
   endtask

   // Response monitor: every consumed response is compared against its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (p0_rsp_vld && p0_rsp_rdy) begin
            if (expQ0.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL p0_unexpected_rsp: got data %h, expected no response", p0_rsp_data);
            end else begin
               checkOutput("p0_rsp_data", p0_rsp_data, expQ0.pop_front());
            end
         end
         if (p1_rsp_vld && p1_rsp_rdy) begin
            if (expQ1.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL p1_unexpected_rsp: got data %h, expected no response", p1_rsp_data);
            end else begin
               checkOutput("p1_rsp_data", p1_rsp_data, expQ1.pop_front());
            end
         end
      end
   end

   // Grant logger, plus the rule that only one port is ever granted, and only when asking.
   always @(negedge clk) begin
      if (rst_n) begin
         if (p0_req_rdy) gntLog.push_back(0);
         if (p1_req_rdy) gntLog.push_back(1);
         if ((p0_req_rdy && p1_req_rdy) || (p0_req_rdy && !p0_req_vld) ||
             (p1_req_rdy && !p1_req_vld)) begin
            checks++; failures++;
            $display("[TB] FAIL grant_legal: rdy=%b%b vld=%b%b, expected single grant to a valid port",
                     p1_req_rdy, p0_req_rdy, p1_req_vld, p0_req_vld);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      p0_req_vld = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_p0_rsp_vld", 32'(p0_rsp_vld), 32'd0);
      checkOutput("reset_p1_rsp_vld", 32'(p1_rsp_vld), 32'd0);
      checkOutput("reset_p0_rsp_data", p0_rsp_data, 32'd0);
      checkOutput("reset_p1_rsp_data", p1_rsp_data, 32'd0);
      checkOutput("reset_ram_ce", 32'(ram_ce), 32'd0);
      checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
      checkOutput("reset_p0_req_rdy", 32'(p0_req_rdy), 32'd0);
      p0_req_vld = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("[TB] write then read on port 0");
      applyStimulus(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0);
      checkOutput("write_rsp_latency", 32'(p0_rsp_vld), 32'd1);
      applyStimulus(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF);

      $display("[TB] alternating grants under contention");
      applyStimulus(0, 1'b1, 8'h01, 32'h01010101, 4'hF, 32'h0);
      applyStimulus(1, 1'b1, 8'h02, 32'h02020202, 4'hF, 32'h0);
      gntLog.delete();
      fork
         begin
            applyStimulus(0, 1'b0, 8'h01, 32'h0, 4'h0, 32'h01010101);
            applyStimulus(0, 1'b0, 8'h01, 32'h0, 4'h0, 32'h01010101);
         end
         begin
            applyStimulus(1, 1'b0, 8'h02, 32'h0, 4'h0, 32'h02020202);
            applyStimulus(1, 1'b0, 8'h02, 32'h0, 4'h0, 32'h02020202);
         end
      join
      checkOutput("alt_grant_count", 32'(gntLog.size()), 32'd4);
      if (gntLog.size() >= 4) begin
         checkOutput("alt_grant_0", 32'(gntLog[0]), 32'd0);
         checkOutput("alt_grant_1", 32'(gntLog[1]), 32'd1);
         checkOutput("alt_grant_2", 32'(gntLog[2]), 32'd0);
         checkOutput("alt_grant_3", 32'(gntLog[3]), 32'd1);
      end

      $display("[TB] partial byte mask write");
      applyStimulus(0, 1'b1, 8'h20, 32'h11223344, 4'hF, 32'h0);
      applyStimulus(0, 1'b1, 8'h20, 32'h0000ABCD, 4'h3, 32'h0);
      applyStimulus(0, 1'b0, 8'h20, 32'h0, 4'h0, 32'h1122ABCD);

      $display("[TB] port 0 stalled response, port 1 keeps streaming");
      applyStimulus(0, 1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      p0_rsp_rdy = 1'b0;
      applyStimulus(0, 1'b0, 8'h30, 32'h0, 4'h0, 32'hCAFEF00D);
      fork
         applyStimulus(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF);
         for (int i = 0; i < 5; i++) applyStimulus(1, 1'b0, 8'h02, 32'h0, 4'h0, 32'h02020202);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               checkOutput("stall_p0_rsp_vld", 32'(p0_rsp_vld), 32'd1);
               checkOutput("stall_p0_rsp_data", p0_rsp_data, 32'hCAFEF00D);
               checkOutput("stall_p0_no_grant", 32'(p0_req_rdy), 32'd0);
               checkOutput("stall_p1_served", 32'(p1_req_rdy), 32'd1);
            end
            @(posedge clk); #1;
            p0_rsp_rdy = 1'b1;
         end
      join

      $display("[TB] port 0 streaming at full rate");
      for (int i = 0; i < 8; i++)
         applyStimulus(0, 1'b1, 8'h40 + 8'(i), 32'hA5000000 | 32'(i), 4'hF, 32'h0);
      fork
         for (int i = 0; i < 8; i++)
            applyStimulus(0, 1'b0, 8'h40 + 8'(i), 32'h0, 4'h0, 32'hA5000000 | 32'(i));
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               checkOutput("stream_ram_ce", 32'(ram_ce), 32'd1);
            end
         end
      join

      $display("[TB] reset while port 1 slot is full");
      p1_rsp_rdy = 1'b0;
      applyStimulus(1, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF);
      applyStimulus(0, 1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF);
      @(negedge clk);
      #2;
      checkOutput("pre_reset_p1_rsp_vld", 32'(p1_rsp_vld), 32'd1);
      checkOutput("pre_reset_p1_rsp_data", p1_rsp_data, 32'hDEADBEEF);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_p1_rsp_vld", 32'(p1_rsp_vld), 32'd0);
      checkOutput("mid_reset_p1_rsp_data", p1_rsp_data, 32'd0);
      checkOutput("mid_reset_p0_rsp_vld", 32'(p0_rsp_vld), 32'd0);
      checkOutput("mid_reset_ram_ce", 32'(ram_ce), 32'd0);
      expQ1.delete();
      p1_rsp_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("post_reset_p0_rsp_vld", 32'(p0_rsp_vld), 32'd0);
         checkOutput("post_reset_p1_rsp_vld", 32'(p1_rsp_vld), 32'd0);
      end
      @(posedge clk); #1;
      gntLog.delete();
      fork
         applyStimulus(0, 1'b0, 8'h01, 32'h0, 4'h0, 32'h01010101);
         applyStimulus(1, 1'b0, 8'h02, 32'h0, 4'h0, 32'h02020202);
      join
      checkOutput("post_reset_grant_count", 32'(gntLog.size()), 32'd2);
      if (gntLog.size() >= 2) begin
         checkOutput("post_reset_first_grant", 32'(gntLog[0]), 32'd0);
         checkOutput("post_reset_second_grant", 32'(gntLog[1]), 32'd1);
      end

      repeat (5) @(negedge clk);
      checkOutput("p0_queue_drained", 32'(expQ0.size()), 32'd0);
      checkOutput("p1_queue_drained", 32'(expQ1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
